// File: rtl/player_grid_control_if.sv
// Direction encoding shared by the game blocks, and the port bundle of the player grid controller.
// The master modport is the side that drives the game (tick source, renderer); the slave side is the grid.
package game_pkg;

  typedef enum logic [2:0] {
    DIR_WAIT  = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_UP    = 3'd4
  } dir_t;

  // True when b would reverse a player straight back onto its own neck.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    case (a)
      DIR_RIGHT: return b == DIR_LEFT;
      DIR_LEFT:  return b == DIR_RIGHT;
      DIR_DOWN:  return b == DIR_UP;
      DIR_UP:    return b == DIR_DOWN;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

interface player_grid_control_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 8,
  parameter int TILE_W      = $clog2(NUM_PLAYERS + 1)
);
  logic                     start;
  logic                     step;
  game_pkg::dir_t           dir [NUM_PLAYERS];
  logic [COORD_W-1:0]       rd_x;
  logic [COORD_W-1:0]       rd_y;
  logic [TILE_W-1:0]        rd_tile;
  logic [COORD_W-1:0]       pos_x [NUM_PLAYERS];
  logic [COORD_W-1:0]       pos_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]   alive;
  logic [NUM_PLAYERS-1:0]   collision;
  logic                     running;
  logic                     game_over;
  logic [TILE_W-1:0]        winner;

  modport master (
    output start, step, dir, rd_x, rd_y,
    input  rd_tile, pos_x, pos_y, alive, collision, running, game_over, winner
  );

  modport slave (
    input  start, step, dir, rd_x, rd_y,
    output rd_tile, pos_x, pos_y, alive, collision, running, game_over, winner
  );
endinterface

// File: rtl/player_grid_control.sv
// Light-cycle style grid: players leave trails on a MAP_W x MAP_H tile map and die on walls,
// trails or head-on target clashes. The map is register based so it can be cleared in one cycle.
module player_grid_control #(
  parameter int MAP_W       = 32,
  parameter int MAP_H       = 24,
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 8,
  localparam int TILE_W     = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  player_grid_control_if.slave bus
);
  import game_pkg::*;

  localparam int CELLS = MAP_W * MAP_H;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [COORD_W-1:0] MAP_W_C = COORD_W'(MAP_W);
  localparam logic [COORD_W-1:0] MAP_H_C = COORD_W'(MAP_H);
  localparam logic [COORD_W-1:0] START_Y = COORD_W'(MAP_H / 2);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

  state_t                 state_reg;
  logic [TILE_W-1:0]      map_mem [CELLS];
  logic [COORD_W-1:0]     head_x_reg [NUM_PLAYERS];
  logic [COORD_W-1:0]     head_y_reg [NUM_PLAYERS];
  dir_t                   heading_reg [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] alive_reg;
  logic [NUM_PLAYERS-1:0] collision_reg;
  logic                   running_reg;
  logic                   game_over_reg;
  logic [TILE_W-1:0]      winner_reg;

  logic [COORD_W-1:0]     tgt_x [NUM_PLAYERS];
  logic [COORD_W-1:0]     tgt_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] moving;
  logic [NUM_PLAYERS-1:0] blocked;
  logic [NUM_PLAYERS-1:0] alive_next;
  logic [TILE_W-1:0]      winner_next;
  logic                   end_round;
  logic                   init_round;

  function automatic logic [COORD_W-1:0] start_x(input int p);
    return COORD_W'((p + 1) * MAP_W / (NUM_PLAYERS + 1));
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return IDX_W'(int'(y) * MAP_W + int'(x));
  endfunction

  // Move evaluation: every check looks at the map as it stands before this step.
  always_comb begin
    int survivors;
    moving      = '0;
    blocked     = '0;
    winner_next = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      tgt_x[p]  = head_x_reg[p];
      tgt_y[p]  = head_y_reg[p];
      moving[p] = alive_reg[p] && (heading_reg[p] != DIR_WAIT);
      case (heading_reg[p])
        DIR_RIGHT: tgt_x[p] = head_x_reg[p] + 1'b1;
        DIR_LEFT:  tgt_x[p] = head_x_reg[p] - 1'b1;
        DIR_DOWN:  tgt_y[p] = head_y_reg[p] + 1'b1;
        DIR_UP:    tgt_y[p] = head_y_reg[p] - 1'b1;
        default:   ;
      endcase
      if (moving[p]) begin
        if (tgt_x[p] >= MAP_W_C || tgt_y[p] >= MAP_H_C) begin
          blocked[p] = 1'b1;
        end else if (map_mem[cell_idx(tgt_x[p], tgt_y[p])] != '0) begin
          blocked[p] = 1'b1;
        end
      end
    end
    // Two movers aiming at the same cell both die, even if that cell is empty.
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int q = 0; q < NUM_PLAYERS; q++) begin
        if (p != q && moving[p] && moving[q] &&
            tgt_x[p] == tgt_x[q] && tgt_y[p] == tgt_y[q]) begin
          blocked[p] = 1'b1;
        end
      end
    end
    alive_next = alive_reg & ~blocked;
    survivors  = $countones(alive_next);
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (alive_next[p] && survivors == 1) begin
        winner_next = TILE_W'(p + 1);
      end
    end
    if (NUM_PLAYERS >= 2) begin
      end_round = (survivors <= 1);
    end else begin
      end_round = (survivors == 0);
    end
  end

  assign init_round = rst || (bus.start && state_reg != ST_RUN);

  always_ff @(posedge clk) begin
    if (init_round) begin
      for (int c = 0; c < CELLS; c++) begin
        map_mem[c] <= '0;
      end
      // Head tiles are written after the clear so they win the last assignment.
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        head_x_reg[p]  <= start_x(p);
        head_y_reg[p]  <= START_Y;
        heading_reg[p] <= DIR_WAIT;
        map_mem[cell_idx(start_x(p), START_Y)] <= TILE_W'(p + 1);
      end
      alive_reg     <= '1;
      collision_reg <= '0;
      winner_reg    <= '0;
      game_over_reg <= 1'b0;
      running_reg   <= !rst;
      state_reg     <= rst ? ST_IDLE : ST_RUN;
    end else if (state_reg == ST_RUN) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (bus.dir[p] != DIR_WAIT && !is_opposite(heading_reg[p], bus.dir[p])) begin
          heading_reg[p] <= bus.dir[p];
        end
      end
      if (bus.step) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (moving[p] && !blocked[p]) begin
            head_x_reg[p] <= tgt_x[p];
            head_y_reg[p] <= tgt_y[p];
            map_mem[cell_idx(tgt_x[p], tgt_y[p])] <= TILE_W'(p + 1);
          end
        end
        alive_reg     <= alive_next;
        collision_reg <= collision_reg | blocked;
        if (end_round) begin
          state_reg     <= ST_OVER;
          running_reg   <= 1'b0;
          game_over_reg <= 1'b1;
          winner_reg    <= winner_next;
        end
      end
    end
  end

  always_comb begin
    bus.rd_tile = '0;
    if (bus.rd_x < MAP_W_C && bus.rd_y < MAP_H_C) begin
      bus.rd_tile = map_mem[cell_idx(bus.rd_x, bus.rd_y)];
    end
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pos
    assign bus.pos_x[gi] = head_x_reg[gi];
    assign bus.pos_y[gi] = head_y_reg[gi];
  end

  assign bus.alive     = alive_reg;
  assign bus.collision = collision_reg;
  assign bus.running   = running_reg;
  assign bus.game_over = game_over_reg;
  assign bus.winner    = winner_reg;

endmodule

// File: tb/tb_player_grid_control.sv
// Bench for player_grid_control: a cell-grid game model compared every cycle, plus
// directed scenarios with literal expectations for the default 32x24 two-player map.
module tb_player_grid_control;
  import game_pkg::*;

  localparam int MAP_W = 32;
  localparam int MAP_H = 24;
  localparam int NP    = 2;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_grid_control_if #(.NUM_PLAYERS(NP), .COORD_W(CW)) bus ();

  player_grid_control #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .NUM_PLAYERS(NP), .COORD_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- game model ----------------
  int grid [MAP_W][MAP_H];
  int px [NP];
  int py [NP];
  int hd [NP];
  bit alv [NP];
  bit col [NP];
  int mode = 0;          // 0 idle, 1 run, 2 over
  int win  = 0;
  bit model_valid = 0;
  int DX  [5] = '{0, 1, -1, 0, 0};
  int DY  [5] = '{0, 0, 0, 1, -1};
  int OPP [5] = '{0, 2, 1, 4, 3};

  task automatic m_init(input int new_mode);
    for (int x = 0; x < MAP_W; x++)
      for (int y = 0; y < MAP_H; y++) grid[x][y] = 0;
    for (int p = 0; p < NP; p++) begin
      px[p] = (p + 1) * MAP_W / (NP + 1);
      py[p] = MAP_H / 2;
      hd[p] = 0;
      alv[p] = 1;
      col[p] = 0;
      grid[px[p]][py[p]] = p + 1;
    end
    win  = 0;
    mode = new_mode;
  endtask

  task automatic m_step();
    int tx [NP];
    int ty [NP];
    bit mv [NP];
    bit die [NP];
    int n;
    int last;
    for (int p = 0; p < NP; p++) begin
      mv[p]  = alv[p] && hd[p] != 0;
      tx[p]  = (px[p] + DX[hd[p]]) % (1 << CW);
      ty[p]  = (py[p] + DY[hd[p]]) % (1 << CW);
      if (tx[p] < 0) tx[p] += (1 << CW);
      if (ty[p] < 0) ty[p] += (1 << CW);
      die[p] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      if (!mv[p]) continue;
      if (tx[p] >= MAP_W || ty[p] >= MAP_H) die[p] = 1;
      else if (grid[tx[p]][ty[p]] != 0) die[p] = 1;
      for (int q = 0; q < NP; q++)
        if (q != p && mv[q] && tx[q] == tx[p] && ty[q] == ty[p]) die[p] = 1;
    end
    for (int p = 0; p < NP; p++) begin
      if (!mv[p]) continue;
      if (die[p]) begin
        alv[p] = 0;
        col[p] = 1;
      end else begin
        px[p] = tx[p];
        py[p] = ty[p];
        grid[tx[p]][ty[p]] = p + 1;
      end
    end
    n = 0;
    last = -1;
    for (int p = 0; p < NP; p++) if (alv[p]) begin n++; last = p; end
    if ((NP >= 2 && n <= 1) || (NP == 1 && n == 0)) begin
      mode = 2;
      win  = (n == 1) ? last + 1 : 0;
    end
  endtask

  function automatic int m_tile(input int x, input int y);
    if (x >= MAP_W || y >= MAP_H) return 0;
    return grid[x][y];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init(0);
      model_valid = 1;
    end else if (bus.start && mode != 1) begin
      m_init(1);
    end else if (mode == 1) begin
      if (bus.step) m_step();
      for (int p = 0; p < NP; p++) begin
        int d;
        d = int'(bus.dir[p]);
        if (d != 0 && d != OPP[hd[p]]) hd[p] = d;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      int a;
      int c;
      a = 0;
      c = 0;
      for (int p = 0; p < NP; p++) begin
        chk("model_pos_x", bus.pos_x[p], px[p]);
        chk("model_pos_y", bus.pos_y[p], py[p]);
        if (alv[p]) a |= (1 << p);
        if (col[p]) c |= (1 << p);
      end
      chk("model_alive", bus.alive, a);
      chk("model_collision", bus.collision, c);
      chk("model_running", bus.running, mode == 1);
      chk("model_game_over", bus.game_over, mode == 2);
      chk("model_winner", bus.winner, win);
      chk("model_rd_tile", bus.rd_tile, m_tile(int'(bus.rd_x), int'(bus.rd_y)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_steps(input int n);
    repeat (n) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
    end
  endtask

  task automatic set_dir(input int p, input dir_t d);
    bus.dir[p] = d;
    tick();
    bus.dir[p] = DIR_WAIT;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic read_tile(input int x, input int y, output int t);
    bus.rd_x = CW'(x);
    bus.rd_y = CW'(y);
    #1;
    t = int'(bus.rd_tile);
  endtask

  task automatic chk_tile(input string name, input int x, input int y, input int exp);
    int t;
    read_tile(x, y, t);
    chk(name, t, exp);
  endtask

  task automatic sweep_map();
    for (int x = 0; x < MAP_W + 2; x++)
      for (int y = 0; y < MAP_H + 2; y++) begin
        int t;
        read_tile(x, y, t);
        chk("sweep_tile", t, m_tile(x, y));
      end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.step  = 1'b0;
    bus.rd_x  = '0;
    bus.rd_y  = '0;
    for (int p = 0; p < NP; p++) bus.dir[p] = DIR_WAIT;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset, step ignored outside RUN
    chk("idle_running", bus.running, 0);
    chk("idle_alive", bus.alive, 3);
    do_steps(1);
    chk("idle_step_ignored", bus.pos_x[0], 10);

    // Round start
    pulse_start();
    chk_tile("start_tile_10_12", 10, 12, 1);
    chk_tile("start_tile_21_12", 21, 12, 2);
    chk_tile("start_tile_0_0", 0, 0, 0);
    chk_tile("start_tile_40_5", 40, 5, 0);
    chk_tile("start_tile_0_24", 0, 24, 0);
    chk("start_alive", bus.alive, 3);
    chk("start_running", bus.running, 1);

    // P0 runs right into P1's head
    set_dir(0, DIR_RIGHT);
    do_steps(10);
    chk("right10_pos_x0", bus.pos_x[0], 20);
    chk("right10_game_over", bus.game_over, 0);
    do_steps(1);
    chk("right11_collision", bus.collision, 1);
    chk("right11_game_over", bus.game_over, 1);
    chk("right11_winner", bus.winner, 2);
    chk("right11_pos_x0", bus.pos_x[0], 20);
    do_steps(1);
    chk("over_frozen_pos_x0", bus.pos_x[0], 20);

    // P0 runs left into the wall
    pulse_start();
    set_dir(0, DIR_LEFT);
    do_steps(10);
    chk("left10_pos_x0", bus.pos_x[0], 0);
    do_steps(1);
    chk("left11_collision", bus.collision, 1);
    chk("left11_winner", bus.winner, 2);
    chk_tile("left11_tile_0_12", 0, 12, 1);
    sweep_map();

    // Reversal ignored, then own-trail collision
    pulse_start();
    set_dir(0, DIR_RIGHT);
    do_steps(1);
    set_dir(0, DIR_LEFT);
    do_steps(1);
    chk("reverse_pos_x0", bus.pos_x[0], 12);
    chk_tile("reverse_tile_11_12", 11, 12, 1);
    chk_tile("reverse_tile_12_12", 12, 12, 1);
    chk("reverse_collision", bus.collision, 0);
    pulse_start();
    chk("start_in_run_pos_x0", bus.pos_x[0], 12);
    set_dir(0, DIR_DOWN);
    do_steps(1);
    set_dir(0, DIR_LEFT);
    do_steps(1);
    chk("trail_pos", bus.pos_x[0] * 256 + bus.pos_y[0], 11 * 256 + 13);
    set_dir(0, DIR_UP);
    do_steps(1);
    chk("trail_collision", bus.collision, 1);
    chk("trail_winner", bus.winner, 2);

    // Head-on clash at (15,12)
    do_reset();
    pulse_start();
    set_dir(1, DIR_LEFT);
    do_steps(1);
    set_dir(0, DIR_RIGHT);
    do_steps(4);
    chk("clash4_pos_x0", bus.pos_x[0], 14);
    chk("clash4_pos_x1", bus.pos_x[1], 16);
    do_steps(1);
    chk("clash_collision", bus.collision, 3);
    chk("clash_winner", bus.winner, 0);
    chk("clash_game_over", bus.game_over, 1);
    chk_tile("clash_tile_15_12", 15, 12, 0);
    sweep_map();

    // start with step from OVER: step ignored
    bus.start = 1'b1;
    bus.step  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.step  = 1'b0;
    chk("start_step_running", bus.running, 1);
    chk("start_step_pos_x0", bus.pos_x[0], 10);

    // Reset mid-round
    set_dir(0, DIR_RIGHT);
    do_steps(3);
    chk("mid_pos_x0", bus.pos_x[0], 13);
    do_reset();
    chk("rst_running", bus.running, 0);
    chk_tile("rst_tile_11_12", 11, 12, 0);
    chk("rst_pos_x0", bus.pos_x[0], 10);
    chk("rst_pos_x1", bus.pos_x[1], 21);
    chk("rst_alive", bus.alive, 3);

    // rst beats a coincident start
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_over_start_running", bus.running, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_grid_control.md
PLAYER_GRID_CONTROL -- requirements
Module: player_grid_control

Interface
REQ-001 Parameter MAP_W, default 32, map width in cells.
REQ-002 Parameter MAP_H, default 24, map height in cells.
REQ-003 Parameter NUM_PLAYERS, default 2, number of players, range 1..4.
REQ-004 Parameter COORD_W, default 8, coordinate width; MAP_W and MAP_H SHALL each be less than 2**COORD_W.
REQ-005 Derived TILE_W = $clog2(NUM_PLAYERS+1); tile code 0 = EMPTY, p+1 = trail/head of player p.
REQ-006 clk  in  1  system clock; the block uses one clock.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 start  in  1  one-cycle pulse: initialise the round and enter RUN.
REQ-009 step  in  1  one-cycle movement tick.
REQ-010 dir  in  directions[NUM_PLAYERS]  per-player command (WAIT/RIGHT/LEFT/DOWN/UP, game_pkg).
REQ-011 rd_x, rd_y  in  COORD_W each  renderer read address.
REQ-012 rd_tile  out  TILE_W  combinational map read; 0 when rd_x>=MAP_W or rd_y>=MAP_H.
REQ-013 pos_x, pos_y  out  COORD_W[NUM_PLAYERS]  registered head positions.
REQ-014 alive  out  NUM_PLAYERS  bit p = player p not collided.
REQ-015 collision  out  NUM_PLAYERS  sticky bit p = player p collided this round.
REQ-016 running  out  1  high in RUN.
REQ-017 game_over  out  1  high in OVER.
REQ-018 winner  out  TILE_W  p+1 of the sole survivor; 0 = draw or none.

Function
REQ-019 FSM states IDLE, RUN, OVER; IDLE->RUN and OVER->RUN on start; RUN->OVER on end condition (REQ-027); start in RUN ignored.
REQ-020 Round init (on start): map cleared; player p head at x=(p+1)*MAP_W/(NUM_PLAYERS+1), y=MAP_H/2; heading WAIT; alive all ones; collision, winner 0; done in one cycle.
REQ-021 Each player holds a heading register; on every cycle in RUN a non-WAIT dir[p] replaces heading unless it is the exact opposite of the current heading (ignored); WAIT dir keeps heading.
REQ-022 step ignored outside RUN; step coincident with start in IDLE/OVER ignored.
REQ-023 On step in RUN, each alive player with heading != WAIT targets head +/-1 in heading axis, COORD_W arithmetic; players with heading WAIT or not alive do not move and are not checked.
REQ-024 Moving player p collides if target x>=MAP_W or y>=MAP_H (0-1 wraps out of range), target tile != EMPTY (any player, own trail included), or target equals another moving player's target.
REQ-025 Non-colliding movers: head registers updated, map[target] written p+1; colliders: head frozen, no map write, alive[p]<=0, collision[p]<=1; all updates visible in the cycle after the step.
REQ-026 Collision checks use map contents before the step; simultaneous writes never mask a collision.
REQ-027 End condition, evaluated on post-step alive: NUM_PLAYERS>=2 and popcount(alive)<=1, or NUM_PLAYERS=1 and alive=0; go OVER, winner = survivor p+1, else 0; outputs frozen in OVER.
REQ-028 rd_tile reflects map state registered at the current clock edge; no read latency.

Reset
REQ-029 rst SHALL win over start and step in any state; next cycle: IDLE, map as REQ-020, heads at start, headings WAIT, alive all ones, collision 0, running 0, game_over 0, winner 0.

Verification (defaults; starts P0 (10,12), P1 (21,12))
REQ-030 rst then start -> rd (10,12)=1, (21,12)=2, (0,0)=0, (40,5)=0; alive=2'b11; running=1.
REQ-031 P0 RIGHT, P1 WAIT, 11 steps -> after step 10 pos_x[0]=20; after step 11 collision=2'b01, game_over=1, winner=2, pos_x[0]=20.
REQ-032 P0 LEFT, 11 steps -> after step 10 pos_x[0]=0; step 11 wall: collision[0]=1, winner=2, (0,12)=1 unchanged.
REQ-033 P0 RIGHT, step, dir LEFT, step -> pos_x[0]=12, (11,12)=(12,12)=1, no collision.
REQ-034 P1 LEFT 1 step (P0 WAIT), then P0 RIGHT, 5 steps -> step 5 both target (15,12): collision=2'b11, winner=0, (15,12)=0.
REQ-035 rst asserted mid-RUN after 3 moves -> next cycle IDLE, (11,12)=0, heads at start, alive=2'b11.
